// File: rtl/v_pkg.sv
// Shared types for the v table and its update path.
// upd_t is the unit stored by the ingress FIFO and driven onto the update bus.
package v_pkg;

   typedef logic [7:0]  id_t;
   typedef logic [15:0] key_t;
   typedef logic [11:0] size_t;

   typedef enum logic [1:0] {
      CmdAdd,
      CmdSub,
      CmdSet,
      CmdClr
   } cmd_t;

   typedef struct packed {
      id_t   prod_id;
      cmd_t  cmd;
      key_t  key;
      size_t size;
   } upd_t;

   // Hazard spacing counter width; GAP must fit below its saturation value.
   localparam int unsigned HzCntW = 3;
   localparam logic [HzCntW-1:0] HzCntMax = '1;

   function automatic logic [HzCntW-1:0] hz_cnt_step(input logic [HzCntW-1:0] cnt);
      return (cnt == HzCntMax) ? cnt : cnt + HzCntW'(1);
   endfunction

endpackage

// File: rtl/v_upd_fifo.sv
// In-order FIFO for update commands. Pointers wrap naturally; a separate
// registered level distinguishes full from empty.
module v_upd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic [W-1:0]            wdata_i,
   input  logic                    pop_i,
   output logic [W-1:0]            head_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [LvlW-1:0] LevelFull = LvlW'(DEPTH);

   logic [W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0] level_q, level_d;
   logic            do_push, do_pop;

   assign full_o  = (level_q == LevelFull);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: a flushed level makes stale entries unreachable.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/v_upd_ingress.sv
// Ingress buffer in front of the v update bus: FIFO, busy gating and registered issue.
// Define V_UPD_INGRESS_HAZARD_EN to build the same-ID spacing tracker (GAP).
module v_upd_ingress
   import v_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned GAP   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_in_vld,
   output logic                   o_in_rdy,
   input  id_t                    i_in_prod_id,
   input  cmd_t                   i_in_cmd,
   input  key_t                   i_in_key,
   input  size_t                  i_in_size,
   input  logic                   i_busy,
   output logic                   o_upd_vld_r,
   output id_t                    o_upd_prod_id_r,
   output cmd_t                   o_upd_cmd_r,
   output key_t                   o_upd_key_r,
   output size_t                  o_upd_size_r,
   output logic [$clog2(DEPTH):0] o_level_r,
   output logic                   o_empty_r
);

   upd_t in_upd;
   upd_t head;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic issue;
   logic hazard;

   upd_t upd_q, upd_d;
   logic vld_q, vld_d;

   assign in_upd = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};

   assign o_in_rdy = !fifo_full;
   assign push     = i_in_vld && o_in_rdy;
   assign issue    = !fifo_empty && !i_busy && !hazard;

   v_upd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(upd_t))
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i (in_upd),
      .pop_i   (issue),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (o_level_r)
   );

   assign o_empty_r = fifo_empty;

`ifdef V_UPD_INGRESS_HAZARD_EN
   id_t               last_id_q, last_id_d;
   logic              last_vld_q, last_vld_d;
   logic [HzCntW-1:0] hz_cnt_q, hz_cnt_d;

   always_comb begin
      last_id_d  = last_id_q;
      last_vld_d = last_vld_q;
      hz_cnt_d   = hz_cnt_step(hz_cnt_q);
      if (issue) begin
         last_id_d  = head.prod_id;
         last_vld_d = 1'b1;
         hz_cnt_d   = HzCntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_id_q  <= '0;
         last_vld_q <= 1'b0;
         hz_cnt_q   <= '0;
      end else begin
         last_id_q  <= last_id_d;
         last_vld_q <= last_vld_d;
         hz_cnt_q   <= hz_cnt_d;
      end
   end

   // hz_cnt counts cycles since the last issue, so a same-ID head waits until it reaches GAP.
   assign hazard = last_vld_q && (head.prod_id == last_id_q) && (hz_cnt_q < HzCntW'(GAP));
`else
   logic unused_gap;

   assign unused_gap = (GAP > 32'd7);
   assign hazard     = 1'b0;
`endif

   always_comb begin
      vld_d = issue;
      upd_d = upd_q;
      if (issue) begin
         upd_d = head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         upd_q <= '0;
      end else begin
         vld_q <= vld_d;
         upd_q <= upd_d;
      end
   end

   assign o_upd_vld_r     = vld_q;
   assign o_upd_prod_id_r = upd_q.prod_id;
   assign o_upd_cmd_r     = upd_q.cmd;
   assign o_upd_key_r     = upd_q.key;
   assign o_upd_size_r    = upd_q.size;

endmodule

// File: tb/tb_v_upd_ingress.sv
// Directed bench for v_upd_ingress: a queue-based model checked every cycle,
// plus literal timing expectations for each scenario.
module tb_v_upd_ingress;
   import v_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned GAP   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_in_vld;
   logic       o_in_rdy;
   id_t        i_in_prod_id;
   cmd_t       i_in_cmd;
   key_t       i_in_key;
   size_t      i_in_size;
   logic       i_busy;
   logic       o_upd_vld_r;
   id_t        o_upd_prod_id_r;
   cmd_t       o_upd_cmd_r;
   key_t       o_upd_key_r;
   size_t      o_upd_size_r;
   logic [3:0] o_level_r;
   logic       o_empty_r;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   v_upd_ingress #(
      .DEPTH (DEPTH),
      .GAP   (GAP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_in_vld        (i_in_vld),
      .o_in_rdy        (o_in_rdy),
      .i_in_prod_id    (i_in_prod_id),
      .i_in_cmd        (i_in_cmd),
      .i_in_key        (i_in_key),
      .i_in_size       (i_in_size),
      .i_busy          (i_busy),
      .o_upd_vld_r     (o_upd_vld_r),
      .o_upd_prod_id_r (o_upd_prod_id_r),
      .o_upd_cmd_r     (o_upd_cmd_r),
      .o_upd_key_r     (o_upd_key_r),
      .o_upd_size_r    (o_upd_size_r),
      .o_level_r       (o_level_r),
      .o_empty_r       (o_empty_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic upd_t mk(input id_t id);
      upd_t u;
      u.prod_id = id;
      u.cmd     = cmd_t'(id[1:0]);
      u.key     = {id, ~id};
      u.size    = {id[3:0], id};
      return u;
   endfunction

   // ---------------- model and per-cycle compare ----------------
   upd_t mq[$];
   upd_t exp_upd;
   logic exp_vld;
   logic mdl_ok   = 1'b0;
   logic have_last;
   id_t  last_id;
   int   last_cyc;
   int   log_cyc[$];
   int   log_id[$];
   int   max_lvl;

   function automatic logic mdl_hazard(input id_t id);
`ifdef V_UPD_INGRESS_HAZARD_EN
      return have_last && (id == last_id) && ((cyc - last_cyc) < int'(GAP));
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      logic issue;
      forever begin
         @(negedge clk);
         if (mdl_ok) begin
            check("vld", 64'(o_upd_vld_r), 64'(exp_vld));
            check("payload", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}),
                  64'(exp_upd));
            check("level", 64'(o_level_r), 64'(mq.size()));
            check("empty", 64'(o_empty_r), 64'(mq.size() == 0));
            check("rdy", 64'(o_in_rdy), 64'(mq.size() < DEPTH));
         end
         if (o_upd_vld_r === 1'b1) begin
            log_cyc.push_back(cyc);
            log_id.push_back(int'(o_upd_prod_id_r));
         end
         if (int'(o_level_r) > max_lvl) max_lvl = int'(o_level_r);
         if (rst) begin
            mq.delete();
            exp_vld   = 1'b0;
            exp_upd   = '0;
            have_last = 1'b0;
            mdl_ok    = 1'b1;
         end else if (mdl_ok) begin
            issue   = (mq.size() > 0) && !i_busy && !mdl_hazard(mq[0].prod_id);
            exp_vld = issue;
            if (issue) begin
               exp_upd   = mq.pop_front();
               have_last = 1'b1;
               last_id   = exp_upd.prod_id;
               last_cyc  = cyc;
            end
            if (i_in_vld && (mq.size() < DEPTH || issue && mq.size() == DEPTH - 1)) begin
               // rdy is decided on the level at the start of the cycle
               if (mq.size() + (issue ? 1 : 0) < DEPTH) mq.push_back(mk(i_in_prod_id));
            end
         end
         cyc++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive(input id_t id);
      upd_t u;
      u            = mk(id);
      i_in_vld     = 1'b1;
      i_in_prod_id = u.prod_id;
      i_in_cmd     = u.cmd;
      i_in_key     = u.key;
      i_in_size    = u.size;
   endtask

   task automatic idle();
      i_in_vld = 1'b0;
   endtask

   task automatic clear_log();
      log_cyc.delete();
      log_id.delete();
      max_lvl = 0;
   endtask

   function automatic int nth_out(input int id, input int n);
      int k = 0;
      foreach (log_id[i]) begin
         if (log_id[i] == id) begin
            if (k == n) return log_cyc[i];
            k++;
         end
      end
      return -1;
   endfunction

   function automatic logic has_out(input int c);
      foreach (log_cyc[i]) if (log_cyc[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic ids_in_order(input int first, input int n);
      if (log_id.size() != n) return 1'b0;
      for (int i = 0; i < n; i++) if (log_id[i] != first + i) return 1'b0;
      return 1'b1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int b, k, r, t, e2, e3;
      rst = 1'b1;
      i_busy = 1'b0;
      i_in_vld = 1'b0;
      i_in_prod_id = '0;
      i_in_cmd = CmdAdd;
      i_in_key = '0;
      i_in_size = '0;
      step();
      step();
      check("reset_vld", 64'(o_upd_vld_r), 64'd0);
      check("reset_payload", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}),
            64'd0);
      check("reset_level", 64'(o_level_r), 64'd0);
      check("reset_empty", 64'(o_empty_r), 64'd1);
      check("reset_rdy", 64'(o_in_rdy), 64'd1);
      rst = 1'b0;
      step();

      // Basic flow
      clear_log();
      b = cyc;
      drive(8'd1); step();
      drive(8'd2); step();
      drive(8'd3); step();
      idle(); steps(6);
      check("basic_id1", 64'(nth_out(1, 0)), 64'(b + 2));
      check("basic_id2", 64'(nth_out(2, 0)), 64'(b + 3));
      check("basic_id3", 64'(nth_out(3, 0)), 64'(b + 4));
      check("basic_level_max", 64'(max_lvl), 64'd1);

      // Init backpressure
      clear_log();
      i_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(8'(50 + i));
         check("bp_rdy_fill", 64'(o_in_rdy), 64'd1);
         step();
      end
      drive(8'd58);
      check("bp_rdy_full", 64'(o_in_rdy), 64'd0);
      check("bp_level_full", 64'(o_level_r), 64'd8);
      steps(2);
      check("bp_rdy_held", 64'(o_in_rdy), 64'd0);
      k = cyc;
      i_busy = 1'b0;
      step();
      check("bp_rdy_resume", 64'(o_in_rdy), 64'd1);
      step();
      idle(); steps(12);
      for (int i = 0; i < 9; i++) check("bp_out", 64'(nth_out(50 + i, 0)), 64'(k + 1 + i));

      // Same-ID spacing
      clear_log();
      b = cyc;
      drive(8'd5); step();
      drive(8'd5); step();
      drive(8'd6); step();
      idle(); steps(10);
      t = b + 2;
`ifdef V_UPD_INGRESS_HAZARD_EN
      e2 = t + int'(GAP);
      e3 = t + int'(GAP) + 1;
`else
      e2 = t + 1;
      e3 = t + 2;
`endif
      check("hz_first", 64'(nth_out(5, 0)), 64'(t));
      check("hz_second", 64'(nth_out(5, 1)), 64'(e2));
      check("hz_other", 64'(nth_out(6, 0)), 64'(e3));

      // Busy mid-stream
      clear_log();
      b = cyc;
      for (int i = 0; i < 10; i++) begin
         i_busy = (i == 5);
         drive(8'(10 + i));
         step();
      end
      i_busy = 1'b0;
      idle(); steps(8);
      check("busy_first", 64'(nth_out(10, 0)), 64'(b + 2));
      check("busy_gap", 64'(has_out(b + 6)), 64'd0);
      check("busy_resume", 64'(has_out(b + 7)), 64'd1);
      check("busy_order", 64'(ids_in_order(10, 10)), 64'd1);

      // Simultaneous push/pop at level 4
      clear_log();
      i_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(8'(20 + i));
         step();
      end
      i_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("pp_level", 64'(o_level_r), 64'd4);
         drive(8'(24 + i));
         step();
      end
      check("pp_level_end", 64'(o_level_r), 64'd4);
      idle(); steps(10);
      check("pp_order", 64'(ids_in_order(20, 14)), 64'd1);

      // Reset mid-operation
      i_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(8'(40 + i));
         step();
      end
      idle();
      i_busy = 1'b0;
      step();
      r = cyc;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_level", 64'(o_level_r), 64'd0);
      check("rst_vld", 64'(o_upd_vld_r), 64'd0);
      check("rst_empty", 64'(o_empty_r), 64'd1);
      clear_log();
      b = cyc;
      check("rst_cycle", 64'(b), 64'(r + 1));
      drive(8'd40); step();
      drive(8'd40); step();
      idle(); steps(10);
`ifdef V_UPD_INGRESS_HAZARD_EN
      e2 = b + 2 + int'(GAP);
`else
      e2 = b + 3;
`endif
      check("rst_first", 64'(nth_out(40, 0)), 64'(b + 2));
      check("rst_second", 64'(nth_out(40, 1)), 64'(e2));
      check("rst_no_stale", 64'(log_id.size()), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/v_upd_ingress.md
# v_upd_ingress

Ingress stage that sits directly upstream of the `v` update bus (`i_upd_*`). It accepts update commands from the producer over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It withholds issue while the table is initialising (`o_busy_r` of `v`), and replays commands one per cycle as single-cycle pulses on registered `o_upd_*_r` outputs. An optional hazard tracker spaces consecutive commands to the same product ID so that the downstream read-modify-write pipeline never sees back-to-back collisions.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `GAP`, default 2: minimum issue spacing in cycles for two consecutive commands with equal prod_id; legal range 1..7 (1 = no stall).

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `i_in_vld` in 1: producer command valid.
- `o_in_rdy` out 1: accept; equals !full, driven from registered count.
- `i_in_prod_id` in `v_pkg::id_t`; `i_in_cmd` in `v_pkg::cmd_t`; `i_in_key` in `v_pkg::key_t`; `i_in_size` in `v_pkg::size_t`: command payload.
- `i_busy` in 1: table init in progress; connect to `v.o_busy_r`.
- `o_upd_vld_r` out 1: issued command valid (one-cycle pulse per command).
- `o_upd_prod_id_r`, `o_upd_cmd_r`, `o_upd_key_r`, `o_upd_size_r` out: issued payload; connect to `v.i_upd_*`.
- `o_level_r` out $clog2(DEPTH)+1: FIFO occupancy.
- `o_empty_r` out 1: occupancy == 0.

## Operation
- Push: `i_in_vld && o_in_rdy`. Payload is written at the tail.
- Pop/issue in cycle c when `!o_empty_r && !i_busy && !hazard`. The head is registered onto `o_upd_*_r` at the end of c. Commands issue strictly in order: a blocked head blocks everything behind it.
- No bypass. A push into an empty FIFO is always written to storage first.
- Push and pop in the same cycle: level unchanged, pointers both advance.
- At full, `o_in_rdy` = 0, even if a pop occurs that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Level is tracked separately to distinguish full from empty.
- Hazard tracker registers:
  - `last_id`: prod_id of the last issued command.
  - `last_vld`: cleared by reset.
  - `hz_cnt`: saturating 3-bit count, set to 1 on issue, incremented each cycle after.
- `hazard` = `last_vld && head.prod_id == last_id && hz_cnt < GAP`. Different IDs never stall.
- `i_busy` is sampled in the issue cycle only. A command already registered on `o_upd_*_r` completes normally.
- Payload outputs hold the last issued value when `o_upd_vld_r` = 0. They are only meaningful when valid.
- Reset at any time flushes the FIFO (level 0), clears the tracker, and zeroes all outputs the following cycle. Queued commands are discarded.

## Timing
Reset values:
- `o_upd_vld_r` = 0; all `o_upd_*_r` payload = 0.
- `o_level_r` = 0; `o_empty_r` = 1; `o_in_rdy` = 1.

Latency and throughput:
- Push accepted in cycle t → earliest `o_upd_vld_r` in cycle t+2.
- Sustained throughput is 1 command/cycle for distinct IDs.
- Same-ID commands issued in cycle c leave the next same-ID command no earlier than cycle c+GAP.
- `i_busy` high in cycle c → `o_upd_vld_r` low in c+1.
- A pop in cycle c raises `o_in_rdy` in c+1 (registered level).

## Configuration
Macro `V_UPD_INGRESS_HAZARD_EN`:
- Defined: the hazard tracker and `GAP` spacing are active.
- Undefined: the tracker is not built and `hazard` = 0. Issue depends only on empty/busy, and `GAP` is ignored.

## Structure
- Add `v_pkg::upd_t` to `v_pkg`: a packed struct {`id_t` prod_id, `cmd_t` cmd, `key_t` key, `size_t` size}. It is used for FIFO storage and the output register.
- Sub-module `v_upd_fifo`: parameterised on `DEPTH` and `W = $bits(v_pkg::upd_t)`. It holds storage, pointers and level and exposes push/pop/head/full/empty.
- The top level holds the issue logic, hazard tracker and output registers.

## Test plan
- **Basic flow:** reset, `i_busy` = 0, push ids 1,2,3 in cycles 0,1,2 → `o_upd_vld_r` in cycles 2,3,4 with ids 1,2,3; `o_level_r` never exceeds 1.
- **Init backpressure:** `i_busy` = 1, push 9 commands, DEPTH=8 → `o_in_rdy` = 0 after the 8th push and the 9th is held by the producer. Deassert `i_busy` in cycle k → 8 consecutive outputs from k+1; `o_in_rdy` = 1 from k+1.
- **Hazard:** macro on, GAP=3, push ids 5,5,6 back-to-back → outputs id5 at t, id5 at t+3, id6 at t+4. With the macro off → t, t+1, t+2.
- **Busy mid-stream:** streaming distinct ids, `i_busy` high in cycle 5 only → `o_upd_vld_r` low in cycle 6, resumes in 7, no command lost or duplicated.
- **Simultaneous push/pop:** at level 4 with one push and one pop per cycle for 10 cycles → `o_level_r` stays 4 and order is preserved across pointer wrap.
- **Reset mid-operation:** 4 entries queued and issuing, assert `rst` one cycle → next cycle level 0, `o_upd_vld_r` 0, `o_empty_r` 1. No stale command issues afterwards, and the first post-reset same-ID command does not stall.
